// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline, with mul/div busy tracking
// and split-handshake dbus / ibus wait state machines.
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              br_d,
  input  logic              hilo_rd_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              regwrite_e,
  input  logic              load_e,
  input  logic              muldiv_start_e,
  input  logic              div_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic              load_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_w,
  input  logic              i_valid,
  input  logic              i_data_ok,
  input  logic              d_valid,
  input  logic              d_write,
  input  logic              d_addr_ok,
  input  logic              d_data_ok,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_e,
  output logic              muldiv_busy,
  output logic              d_addr_acc,
  output logic [1:0]        d_state_dbg,  // 0 idle, 1 address wait, 2 data wait
  output logic              i_state_dbg   // 1 while waiting for ibus data
);

  // Handshake: a bus transfer is in flight while its valid is high; it ends on the
  // cycle the slave returns the final ok (addr_ok for writes, data_ok for reads).
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT);

  typedef enum logic [1:0] {D_IDLE = 2'd0, D_ADDR = 2'd1, D_DATA = 2'd2} d_state_t;
  typedef enum logic {I_IDLE = 1'b0, I_WAIT = 1'b1} i_state_t;

  d_state_t d_state, d_next;
  i_state_t i_state, i_next;
  logic [CW-1:0] md_cnt;

  logic busy, accept, stall_m_raw, stall_e_raw, bubble;
  logic load_use, br_e_haz, br_m_haz, ibus_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] m_rd, input logic m_ok,
                                         input logic [REG_AW-1:0] w_rd, input logic w_ok);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (m_ok && m_rd == src)      sel = 2'b01;
      else if (w_ok && w_rd == src) sel = 2'b10;
    end
    return sel;
  endfunction

  function automatic logic d_src_hit(input logic [REG_AW-1:0] r);
    return (r != '0) && ((use_rs_d && r == rs_d) || (use_rt_d && r == rt_d));
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_cnt  <= '0;
      d_state <= D_IDLE;
      i_state <= I_IDLE;
    end else begin
      if (accept)             md_cnt <= div_e ? DIV_LD : MUL_LD;
      else if (md_cnt != '0)  md_cnt <= md_cnt - CW'(1);
      d_state <= d_next;
      i_state <= i_next;
    end
  end

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE: begin
        if (d_valid && d_addr_ok && !d_write && !d_data_ok) d_next = D_DATA;
        else if (d_valid && !d_addr_ok)                     d_next = D_ADDR;
      end
      D_ADDR: begin
        if (!d_valid)                          d_next = D_IDLE;
        else if (d_addr_ok && !d_write && !d_data_ok) d_next = D_DATA;
        else if (d_addr_ok)                    d_next = D_IDLE;
      end
      D_DATA:  if (d_data_ok) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  always_comb begin
    i_next = i_state;
    case (i_state)
      I_IDLE:  if (i_valid && !i_data_ok) i_next = I_WAIT;
      I_WAIT:  if (i_data_ok) i_next = I_IDLE;
      default: i_next = I_IDLE;
    endcase
  end

  always_comb begin
    busy        = (md_cnt != '0);
    load_use    = load_e && d_src_hit(rd_e);
    br_e_haz    = br_d && regwrite_e && d_src_hit(rd_e);
    br_m_haz    = br_d && load_m && d_src_hit(rd_m);
    ibus_stall  = i_valid && !i_data_ok;
    stall_m_raw = d_valid && !(d_write ? d_addr_ok : d_data_ok);
    stall_e_raw = stall_m_raw || (busy && muldiv_start_e);
    bubble      = load_use || br_e_haz || br_m_haz || ibus_stall || (busy && hilo_rd_d);
    accept      = muldiv_start_e && !stall_e_raw && !busy;

    fwd_rs_d    = 2'b00;
    fwd_rt_d    = 2'b00;
    fwd_rs_e    = 2'b00;
    fwd_rt_e    = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_e     = 1'b0;
    muldiv_busy = 1'b0;
    d_addr_acc  = 1'b0;
    if (resetn) begin
      fwd_rs_d    = fwd_sel(rs_d, rd_m, regwrite_m && !load_m, rd_w, regwrite_w);
      fwd_rt_d    = fwd_sel(rt_d, rd_m, regwrite_m && !load_m, rd_w, regwrite_w);
      fwd_rs_e    = fwd_sel(rs_e, rd_m, regwrite_m && !load_m, rd_w, regwrite_w);
      fwd_rt_e    = fwd_sel(rt_e, rd_m, regwrite_m && !load_m, rd_w, regwrite_w);
      stall_m     = stall_m_raw;
      stall_e     = stall_e_raw;
      stall_d     = stall_e_raw || bubble;
      stall_f     = stall_e_raw || bubble;
      // A held E instruction must not be replaced by a bubble.
      flush_e     = bubble && !stall_e_raw;
      muldiv_busy = busy;
      d_addr_acc  = (d_state == D_DATA);
    end
  end

  assign d_state_dbg = d_state;
  assign i_state_dbg = i_state;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed scenarios plus randomized traffic checked against a transaction-level
// reference model of the hazard unit.
module tb_hazard_unit_mc;
  localparam int AW = 5;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic resetn;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
  logic use_rs_d, use_rt_d, br_d, hilo_rd_d;
  logic regwrite_e, load_e, muldiv_start_e, div_e;
  logic regwrite_m, load_m, regwrite_w;
  logic i_valid, i_data_ok, d_valid, d_write, d_addr_ok, d_data_ok;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, d_state_dbg;
  logic stall_f, stall_d, stall_e, stall_m, flush_e, muldiv_busy, d_addr_acc, i_state_dbg;

  hazard_unit_mc #(.REG_AW(AW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .br_d(br_d), .hilo_rd_d(hilo_rd_d),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .regwrite_e(regwrite_e), .load_e(load_e),
    .muldiv_start_e(muldiv_start_e), .div_e(div_e),
    .rd_m(rd_m), .regwrite_m(regwrite_m), .load_m(load_m),
    .rd_w(rd_w), .regwrite_w(regwrite_w),
    .i_valid(i_valid), .i_data_ok(i_data_ok),
    .d_valid(d_valid), .d_write(d_write), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_e(flush_e), .muldiv_busy(muldiv_busy), .d_addr_acc(d_addr_acc),
    .d_state_dbg(d_state_dbg), .i_state_dbg(i_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: cycles of mul/div left, dbus address accepted / address pending, ibus waiting
  int md_left;
  bit d_taken, d_addr_wait, i_wait;

  logic [1:0] e_fwd_rs_d, e_fwd_rt_d, e_fwd_rs_e, e_fwd_rt_e;
  logic e_stall_f, e_stall_d, e_stall_e, e_stall_m, e_flush, e_busy, e_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
    if (src == 0) return 2'd0;
    if (regwrite_m && !load_m && rd_m == src) return 2'd1;
    if (regwrite_w && rd_w == src) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit reads_d(input logic [AW-1:0] r);
    return r != 0 && ((use_rs_d && rs_d == r) || (use_rt_d && rt_d == r));
  endfunction

  task automatic model_eval();
    bit busy, bubble, sm, se;
    busy   = md_left > 0;
    bubble = (load_e && reads_d(rd_e)) || (br_d && regwrite_e && reads_d(rd_e)) ||
             (br_d && load_m && reads_d(rd_m)) || (i_valid && !i_data_ok) ||
             (busy && hilo_rd_d);
    sm = d_valid && !(d_write ? d_addr_ok : d_data_ok);
    se = sm || (busy && muldiv_start_e);
    e_fwd_rs_d = ref_fwd(rs_d);  e_fwd_rt_d = ref_fwd(rt_d);
    e_fwd_rs_e = ref_fwd(rs_e);  e_fwd_rt_e = ref_fwd(rt_e);
    e_stall_m = sm;  e_stall_e = se;
    e_stall_d = se || bubble;  e_stall_f = se || bubble;
    e_flush = bubble && !se;
    e_busy = busy;  e_acc = d_taken;
    if (!resetn) begin
      {e_fwd_rs_d, e_fwd_rt_d, e_fwd_rs_e, e_fwd_rt_e} = '0;
      {e_stall_f, e_stall_d, e_stall_e, e_stall_m, e_flush, e_busy, e_acc} = '0;
    end
  endtask

  task automatic model_reset();
    md_left = 0; d_taken = 0; d_addr_wait = 0; i_wait = 0;
  endtask

  task automatic model_clock();
    if (!resetn) begin
      model_reset();
      return;
    end
    if (muldiv_start_e && !e_stall_e && md_left == 0) md_left = div_e ? DIV_LAT : MUL_LAT;
    else if (md_left > 0) md_left--;
    if (d_taken) d_taken = !d_data_ok;
    else begin
      d_taken     = d_valid && d_addr_ok && !d_write && !d_data_ok;
      d_addr_wait = d_valid && !d_addr_ok;
    end
    i_wait = i_wait ? !i_data_ok : (i_valid && !i_data_ok);
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    #1;
    model_eval();
    check("fwd_rs_d", fwd_rs_d, e_fwd_rs_d);
    check("fwd_rt_d", fwd_rt_d, e_fwd_rt_d);
    check("fwd_rs_e", fwd_rs_e, e_fwd_rs_e);
    check("fwd_rt_e", fwd_rt_e, e_fwd_rt_e);
    check("stall_f", stall_f, e_stall_f);
    check("stall_d", stall_d, e_stall_d);
    check("stall_e", stall_e, e_stall_e);
    check("stall_m", stall_m, e_stall_m);
    check("flush_e", flush_e, e_flush);
    check("muldiv_busy", muldiv_busy, e_busy);
    check("d_addr_acc", d_addr_acc, e_acc);
    check("d_state", d_state_dbg, d_taken ? 2'd2 : (d_addr_wait ? 2'd1 : 2'd0));
    check("i_state", i_state_dbg, i_wait);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w} = '0;
    {use_rs_d, use_rt_d, br_d, hilo_rd_d, regwrite_e, load_e, muldiv_start_e, div_e} = '0;
    {regwrite_m, load_m, regwrite_w, i_valid, i_data_ok} = '0;
    {d_valid, d_write, d_addr_ok, d_data_ok} = '0;
  endtask

  task automatic rand_inputs();
    rs_d = AW'($urandom_range(0, 3)); rt_d = AW'($urandom_range(0, 3));
    rs_e = AW'($urandom_range(0, 3)); rt_e = AW'($urandom_range(0, 3));
    rd_e = AW'($urandom_range(0, 3)); rd_m = AW'($urandom_range(0, 3));
    rd_w = AW'($urandom_range(0, 3));
    {use_rs_d, use_rt_d, br_d, regwrite_e, load_e, regwrite_m, load_m, regwrite_w} = 8'($urandom);
    hilo_rd_d = ($urandom_range(0, 3) == 0);
    muldiv_start_e = ($urandom_range(0, 7) == 0);
    div_e = ($urandom_range(0, 3) == 0);
    i_valid = $urandom_range(0, 1); i_data_ok = $urandom_range(0, 1);
    if (d_taken) begin
      d_valid = 1; d_write = 0; d_addr_ok = $urandom_range(0, 1);
      d_data_ok = ($urandom_range(0, 2) == 0);
    end else begin
      d_valid = $urandom_range(0, 1); d_write = $urandom_range(0, 1);
      d_addr_ok = $urandom_range(0, 1);
      d_data_ok = !d_write && d_addr_ok && $urandom_range(0, 1);
    end
  endtask

  task automatic pulse_reset();
    resetn = 0;
    model_reset();
    cycle();
    resetn = 1;
  endtask

  int nb, ns;

  initial begin
    idle_inputs();
    resetn = 0;
    model_reset();
    @(negedge clk);
    cycle();
    check("rst_stall_f", stall_f, 0);
    resetn = 1;
    cycle();

    // load-use: lw $3 in E, addu reads $3 in D
    load_e = 1; regwrite_e = 1; rd_e = 3; rs_d = 3; use_rs_d = 1;
    #1; check("tp1_stall_d", stall_d, 1); check("tp1_flush", flush_e, 1);
    cycle();
    idle_inputs(); regwrite_w = 1; rd_w = 3; rs_e = 3;
    #1; check("tp1_fwd_w", fwd_rs_e, 2'd2);
    cycle();
    // M beats W; $0 never forwarded
    regwrite_m = 1; rd_m = 4; regwrite_w = 1; rd_w = 4; rs_e = 4;
    #1; check("tp2_fwd_m", fwd_rs_e, 2'd1);
    cycle();
    rd_m = 0; rd_w = 0; rs_e = 0;
    cycle();
    idle_inputs();

    // div then MFLO waiting in D
    muldiv_start_e = 1; div_e = 1;
    cycle();
    idle_inputs(); hilo_rd_d = 1;
    nb = 0; ns = 0;
    for (int i = 0; i < 40; i++) begin
      #1; if (muldiv_busy) nb++; if (stall_d) ns++;
      cycle();
    end
    check("tp3_busy_cycles", nb, DIV_LAT);
    check("tp3_stall_cycles", ns, DIV_LAT);
    idle_inputs();

    // dbus read: addr_ok cycle 1, data_ok cycle 4
    d_valid = 1; d_addr_ok = 1;
    #1; check("tp4_rd_c1", stall_m, 1);
    cycle();
    d_addr_ok = 0;
    cycle(); cycle();
    d_data_ok = 1;
    #1; check("tp4_rd_c4_stall", stall_m, 0); check("tp4_rd_c4_acc", d_addr_acc, 1);
    cycle();
    // dbus write: addr_ok cycle 2
    idle_inputs(); d_valid = 1; d_write = 1;
    cycle();
    d_addr_ok = 1;
    #1; check("tp4_wr_c2", stall_m, 0);
    cycle();
    idle_inputs();

    // reset mid-div while dbus is in D_DATA
    muldiv_start_e = 1; div_e = 1; d_valid = 1; d_addr_ok = 1;
    cycle();
    muldiv_start_e = 0; d_addr_ok = 0;
    for (int i = 0; i < 13; i++) cycle();
    pulse_reset();
    idle_inputs();
    #1; check("tp5_busy", muldiv_busy, 0); check("tp5_acc", d_addr_acc, 0);
    cycle();

    // dbus stall coincident with load-use
    d_valid = 1; d_addr_ok = 1;
    load_e = 1; rd_e = 5; rs_d = 5; use_rs_d = 1;
    #1; check("tp6_stall_e", stall_e, 1); check("tp6_flush", flush_e, 0);
    cycle();
    d_addr_ok = 0; d_data_ok = 1;
    #1; check("tp6_bubble", flush_e, 1);
    cycle();
    idle_inputs();
    cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      rand_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
